// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared fetch-stage types, widths and state transition helper.
package cpu_fetch_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int INSTR_W    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // Halt wins over resume while running; resume only matters once halted.
    function automatic logic [1:0] next_state(input logic [1:0] s, input logic halt, input logic resume);
        return (s == IDLE) ? RUN : (s == RUN) ? (halt ? HALTED : RUN) : (resume ? RUN : HALTED);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM, control and decode-side signals of the fetch stage.
interface instr_fetch_if #(
    parameter int ADDR_W = cpu_fetch_pkg::ADDR_W_DEF
);
    import cpu_fetch_pkg::*;

    logic [ADDR_W-1:0]  address;
    logic               clken;
    logic [INSTR_W-1:0] q;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               halt;
    logic               resume;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output address, clken, instr, instr_pc, instr_valid,
        input  q, redirect, redirect_addr, halt, resume, instr_ready
    );

    modport slave (
        input  address, clken, instr, instr_pc, instr_valid,
        output q, redirect, redirect_addr, halt, resume, instr_ready
    );

endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: two-entry in-order instruction buffer; the head is a register.
module fetch_buf import cpu_fetch_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] data,
    input  logic [ADDR_W-1:0]  data_pc,
    output logic [1:0]         cnt,
    output logic [INSTR_W-1:0] head,
    output logic [ADDR_W-1:0]  head_pc,
    output logic               valid
);

    logic [INSTR_W-1:0] d0, d1;
    logic [ADDR_W-1:0]  p0, p1;
    logic               pop_ok, to_head, to_tail;
    logic [1:0]         left;

    // A simultaneous pop and push shifts first, then writes the freed slot.
    assign pop_ok  = pop && (cnt != 2'd0);
    assign left    = cnt - {1'b0, pop_ok};
    assign to_head = push && (left == 2'd0);
    assign to_tail = push && (left != 2'd0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            d0  <= '0;
            d1  <= '0;
            p0  <= '0;
            p1  <= '0;
            cnt <= 2'd0;
        end else begin
            d0  <= to_head ? data : pop_ok ? d1 : d0;
            p0  <= to_head ? data_pc : pop_ok ? p1 : p0;
            d1  <= to_tail ? data : d1;
            p1  <= to_tail ? data_pc : p1;
            cnt <= flush ? 2'd0 : left + {1'b0, push};
        end
    end

    assign head    = d0;
    assign head_pc = p0;
    assign valid   = cnt != 2'd0;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: ROM-driven instruction fetch with redirect, halt/resume and a
// two-entry decode buffer.
module instr_fetch import cpu_fetch_pkg::*; #(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic          clock,
    input  logic          reset_n,
    instr_fetch_if.master bus
);

    localparam logic [1:0]        S_IDLE = IDLE;
    localparam logic [1:0]        S_RUN  = RUN;
    localparam logic [ADDR_W-1:0] ONE    = 1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc, pend_pc;
    logic              pend, pop, push, issue;
    logic [1:0]        cnt;
    logic [2:0]        occ;

    // Occupancy counts the in-flight ROM read so the buffer can never overflow.
    assign pop   = bus.instr_valid && bus.instr_ready && !bus.redirect;
    assign push  = pend && !bus.redirect;
    assign occ   = {1'b0, cnt} + {2'b0, pend} - {2'b0, pop};
    assign issue = reset_n && (state == S_RUN) && (bus.redirect || occ < 3'd2);

    assign bus.clken   = issue;
    assign bus.address = (!reset_n || state == S_IDLE) ? RESET_VECTOR :
                         bus.redirect ? bus.redirect_addr : pc;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pc      <= RESET_VECTOR;
            pend    <= 1'b0;
            pend_pc <= '0;
        end else begin
            state   <= next_state(state, bus.halt, bus.resume);
            pc      <= issue ? bus.address + ONE : bus.redirect ? bus.redirect_addr : pc;
            pend    <= issue;
            pend_pc <= bus.address;
        end
    end

    fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (bus.redirect),
        .data    (bus.q),
        .data_pc (pend_pc),
        .cnt     (cnt),
        .head    (bus.instr),
        .head_pc (bus.instr_pc),
        .valid   (bus.instr_valid)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed cycle-by-cycle checks of instr_fetch against
// hand-traced expectations; ROM word equals its address.
module tb_instr_fetch;
    import cpu_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    instr_fetch_if #(.ADDR_W(10)) a ();
    instr_fetch_if #(.ADDR_W(10)) b ();

    instr_fetch #(.ADDR_W(10), .RESET_VECTOR(10'd0)) u_a (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (a.master)
    );

    instr_fetch #(.ADDR_W(10), .RESET_VECTOR(10'd1022)) u_b (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (b.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a.clken) a.q <= {22'd0, a.address};
        if (b.clken) b.q <= {22'd0, b.address};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [9:0] ra, input logic hl, input logic rs, input logic rdy);
        @(posedge clk);
        #1;
        a.redirect      = rd;
        a.redirect_addr = ra;
        a.halt          = hl;
        a.resume        = rs;
        a.instr_ready   = rdy;
        #1;
    endtask

    initial begin
        a.q = '0; b.q = '0;
        a.redirect = 0; a.redirect_addr = '0; a.halt = 0; a.resume = 0; a.instr_ready = 1;
        b.redirect = 0; b.redirect_addr = '0; b.halt = 0; b.resume = 0; b.instr_ready = 1;
        repeat (3) drive(0, 0, 0, 0, 1);
        chk("rst_clken", a.clken, 0);
        chk("rst_addr", a.address, 0);
        chk("rst_valid", a.instr_valid, 0);
        chk("rst_pc", a.instr_pc, 0);
        chk("rst_instr", a.instr, 0);
        chk("rst_addr_b", b.address, 1022);
        // cycle 1: reset released, IDLE
        reset_n = 1'b1;
        #1;
        chk("idle_clken", a.clken, 0);
        for (int c = 2; c <= 9; c++) begin
            drive(0, 0, 0, 0, 1);
            chk("ramp_clken", a.clken, 1);
            chk("ramp_addr", a.address, c - 2);
            chk("ramp_valid", a.instr_valid, (c >= 4) ? 1 : 0);
            if (c >= 4) begin
                chk("ramp_pc", a.instr_pc, c - 4);
                chk("ramp_instr", a.instr, c - 4);
            end
            if (c <= 5) chk("wrap_addr", b.address, (1020 + c) % 1024);
            if (c >= 4 && c <= 7) chk("wrap_pc", b.instr_pc, (1018 + c) % 1024);
        end
        // backpressure: buffer fills with 6,7 and holds
        for (int c = 10; c <= 14; c++) begin
            drive(0, 0, 0, 0, 0);
            chk("bp_clken", a.clken, 0);
            chk("bp_valid", a.instr_valid, 1);
            chk("bp_pc", a.instr_pc, 6);
            chk("bp_instr", a.instr, 6);
        end
        for (int c = 15; c <= 18; c++) begin
            drive(0, 0, 0, 0, 1);
            chk("rel_clken", a.clken, 1);
            chk("rel_addr", a.address, c - 7);
            chk("rel_pc", a.instr_pc, c - 9);
        end
        // redirect with two buffered entries (10, 11)
        drive(0, 0, 0, 0, 0);
        chk("fill_pc", a.instr_pc, 10);
        chk("fill_clken", a.clken, 0);
        drive(1, 10'h200, 0, 0, 1);
        chk("rd_clken", a.clken, 1);
        chk("rd_addr", a.address, 10'h200);
        drive(0, 0, 0, 0, 1);
        chk("rd_flush", a.instr_valid, 0);
        chk("rd_next_addr", a.address, 10'h201);
        drive(0, 0, 0, 0, 1);
        chk("rd_valid", a.instr_valid, 1);
        chk("rd_pc", a.instr_pc, 10'h200);
        chk("rd_instr", a.instr, 10'h200);
        // redirect while a response is arriving: 0x202 must be discarded
        drive(1, 10'h050, 0, 0, 1);
        chk("rd2_pc_before", a.instr_pc, 10'h201);
        chk("rd2_addr", a.address, 10'h050);
        drive(0, 0, 0, 0, 1);
        chk("rd2_flush", a.instr_valid, 0);
        chk("rd2_next_addr", a.address, 10'h051);
        drive(0, 0, 0, 0, 1);
        chk("rd2_pc", a.instr_pc, 10'h050);
        drive(0, 0, 0, 0, 1);
        chk("rd2_pc_next", a.instr_pc, 10'h051);
        chk("rd2_addr_run", a.address, 10'h053);
        // halt: issue 0x54 still happens this cycle, buffer drains
        drive(0, 0, 1, 0, 1);
        chk("halt_clken", a.clken, 1);
        chk("halt_addr", a.address, 10'h054);
        drive(0, 0, 0, 0, 1);
        chk("halted_clken", a.clken, 0);
        chk("drain_pc0", a.instr_pc, 10'h053);
        drive(0, 0, 0, 1, 1);
        chk("resume_clken", a.clken, 0);
        chk("drain_pc1", a.instr_pc, 10'h054);
        drive(0, 0, 0, 0, 1);
        chk("drained", a.instr_valid, 0);
        chk("resumed_clken", a.clken, 1);
        chk("resumed_addr", a.address, 10'h055);
        drive(0, 0, 0, 0, 1);
        chk("resumed_addr2", a.address, 10'h056);
        drive(0, 0, 0, 0, 1);
        chk("resumed_pc", a.instr_pc, 10'h055);
        // redirect + halt together, then redirect while halted
        drive(1, 10'h300, 1, 0, 1);
        chk("rdh_clken", a.clken, 1);
        chk("rdh_addr", a.address, 10'h300);
        drive(0, 0, 0, 0, 1);
        chk("rdh_halted", a.clken, 0);
        chk("rdh_flush", a.instr_valid, 0);
        drive(1, 10'h3f0, 0, 0, 1);
        chk("rdh_pc", a.instr_pc, 10'h300);
        chk("hrd_clken", a.clken, 0);
        drive(0, 0, 0, 1, 1);
        chk("hrd_flush", a.instr_valid, 0);
        chk("hrd_resume_clken", a.clken, 0);
        drive(0, 0, 0, 0, 1);
        chk("hrd_addr", a.address, 10'h3f0);
        chk("hrd_issue", a.clken, 1);
        drive(0, 0, 0, 0, 1);
        chk("hrd_addr2", a.address, 10'h3f1);
        drive(0, 0, 0, 0, 1);
        chk("hrd_pc", a.instr_pc, 10'h3f0);
        chk("pend_clken", a.clken, 1);
        // reset mid-stream with a pending fetch
        drive(0, 0, 0, 0, 1);
        reset_n = 1'b0;
        #1;
        chk("mrst_clken", a.clken, 0);
        chk("mrst_addr", a.address, 0);
        drive(0, 0, 0, 0, 1);
        chk("mrst_valid", a.instr_valid, 0);
        chk("mrst_pc", a.instr_pc, 0);
        chk("mrst_instr", a.instr, 0);
        drive(0, 0, 0, 0, 1);
        reset_n = 1'b1;
        #1;
        chk("mrst_idle", a.clken, 0);
        drive(0, 0, 0, 0, 1);
        chk("mrst_issue", a.clken, 1);
        chk("mrst_issue_addr", a.address, 0);
        drive(0, 0, 0, 0, 1);
        chk("mrst_no_stale", a.instr_valid, 0);
        drive(0, 0, 0, 0, 1);
        chk("mrst_valid2", a.instr_valid, 1);
        chk("mrst_pc2", a.instr_pc, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 10'd0: word address fetched first after reset.
REQ-002 SHALL have parameter ADDR_W, default 10: width of the ROM word address.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous reset, active-low.
REQ-005 SHALL have port address, output, ADDR_W: ROM word address, registered by ROM_CPU on the same edge.
REQ-006 SHALL have port clken, output, 1: ROM clock enable; high means an issue this cycle.
REQ-007 SHALL have port q, input, 32: ROM data, valid one cycle after an issue.
REQ-008 SHALL have port redirect, input, 1: branch/jump, flush and restart.
REQ-009 SHALL have port redirect_addr, input, ADDR_W: redirect target.
REQ-010 SHALL have port halt, input, 1: stop issuing from the next cycle.
REQ-011 SHALL have port resume, input, 1: restart issuing after a halt.
REQ-012 SHALL have port instr, output, 32: instruction to decode.
REQ-013 SHALL have port instr_pc, output, ADDR_W: address of instr.
REQ-014 SHALL have port instr_valid, output, 1: instr/instr_pc valid.
REQ-015 SHALL have port instr_ready, input, 1: decode accepts; pop = instr_valid && instr_ready.

Function
REQ-016 SHALL implement states IDLE, RUN and HALTED; after reset, IDLE lasts exactly one cycle and then moves to RUN.
REQ-017 SHALL issue (clken=1) only in RUN, when redirect=1 or when cnt + pend - pop < 2.
  - cnt = buffered entries, 0..2.
  - pend = issue made in the previous cycle.
REQ-018 SHALL drive address = redirect ? redirect_addr : pc, combinationally.
REQ-019 SHALL advance pc by one on each issue to (issued address + 1), wrapping modulo 2^ADDR_W (1023 -> 0).
REQ-020 SHALL, when pend=1, capture q with pend_pc into a 2-entry in-order buffer; the head of that buffer drives instr, instr_pc and instr_valid.
REQ-021 SHALL deliver the first instr_valid of a fetch exactly 2 cycles after its issue (one cycle ROM latency plus one cycle buffer register), and sustain one instruction per cycle while instr_ready=1.
REQ-022 SHALL hold instr and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-023 SHALL never overflow the buffer, and SHALL never drop or duplicate an instruction apart from redirect flushes.
REQ-024 SHALL treat a pop and a capture in the same cycle as simultaneous: cnt stays unchanged and order is preserved.
REQ-025 SHALL, on redirect=1:
  - flush the buffer;
  - discard the q arriving that cycle;
  - suppress pop;
  - issue redirect_addr in the same cycle if in RUN;
  - set pc = redirect_addr + 1.
REQ-026 SHALL give redirect priority over halt in the same cycle; the redirect issue happens, then the state becomes HALTED.
REQ-027 SHALL, on halt in RUN, move to HALTED with no further issue; a pending response is still captured and the buffer keeps draining.
REQ-028 SHALL, on redirect in HALTED, flush the buffer and set pc = redirect_addr without issuing.
REQ-029 SHALL, on resume in HALTED, move to RUN and issue from the next cycle; resume in RUN or IDLE has no effect.

Reset
REQ-030 SHALL, with reset_n=0 at a rising edge, set:
  - state=IDLE, pc=RESET_VECTOR, pend=0, cnt=0;
  - instr=0, instr_pc=0, instr_valid=0.
REQ-031 SHALL force clken=0 and address=RESET_VECTOR while reset_n=0 and in IDLE.
REQ-032 SHALL abandon any pending ROM response on a reset mid-operation; it is never presented.

Structure
REQ-033 SHALL take the state enum (IDLE/RUN/HALTED), ADDR_W default and the instruction width (32) from shared package cpu_fetch_pkg.
REQ-034 SHALL implement the 2-entry buffer as sub-module fetch_buf (push, pop, flush, cnt, head outputs), instantiated once.

Verification
REQ-035 SHALL cover reset release with instr_ready=1 and ROM word = address:
  - clken first high in cycle 2 with address 0;
  - instr_valid first high in cycle 4 with instr_pc=0;
  - then pcs 1,2,3... one per cycle.
REQ-036 SHALL cover backpressure, instr_ready=0 for 5 cycles:
  - at most 2 buffered and 1 pending;
  - clken low once full;
  - instr held constant;
  - on release the pcs continue in order with no gap or duplicate.
REQ-037 SHALL cover redirect to 0x200 while 2 entries are buffered:
  - same-cycle issue of 0x200;
  - the next instr_valid carries instr_pc=0x200;
  - the old entries are never presented.
REQ-038 SHALL cover halt:
  - clken low from the next cycle;
  - the buffer drains;
  - resume two cycles later issues pc continuing from the last issued address + 1.
REQ-039 SHALL cover wrap with RESET_VECTOR=1022: issued addresses are 1022, 1023, 0, 1.
REQ-040 SHALL cover reset_n=0 asserted mid-stream with a pending fetch: all outputs reach their REQ-030 values, and the fetch restarts at RESET_VECTOR.
